// File: rtl/dpll_backtrack_ctrl.sv
// dpll_backtrack_ctrl: DPLL backtrack controller that owns Stack_bool and unwinds it on conflict.
// Ports: clock/reset (async active-high); decide_valid/ready and conflict_valid/ready handshakes
// from the decision engine; sb_front/sb_full/sb_empty from Stack_bool and sb_wr_en/sb_pop/sb_din
// to it; level = stack occupancy; unassign_valid/level and flip_valid/level pulses; bt_busy;
// sticky unsat and err. Optional build macro BT_STATS_EN adds conflict_cnt and max_level.
// Stack bit: 0 = alternative untried, 1 = alternative already tried.
module dpll_backtrack_ctrl #(
  parameter int DEPTH = 32,
  parameter int LVL_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             decide_valid,
  output logic             decide_ready,
  input  logic             conflict_valid,
  output logic             conflict_ready,
  input  logic             sb_front,
  input  logic             sb_full,
  input  logic             sb_empty,
  output logic             sb_wr_en,
  output logic             sb_pop,
  output logic             sb_din,
  output logic [LVL_W-1:0] level,
  output logic             unassign_valid,
  output logic [LVL_W-1:0] unassign_level,
  output logic             flip_valid,
  output logic [LVL_W-1:0] flip_level,
  output logic             bt_busy,
  output logic             unsat,
  output logic             err
`ifdef BT_STATS_EN
  , output logic [31:0]      conflict_cnt,
  output logic [LVL_W-1:0] max_level
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, FLIP, UNSAT} state_t;
  localparam logic [LVL_W-1:0] TOP = LVL_W'(DEPTH);
  state_t state;
  logic idle, accept, inc, dec;
  logic [LVL_W-1:0] level_next;
  always_comb begin
    idle           = state == IDLE && !reset;
    conflict_ready = idle;
    decide_ready   = idle && !sb_full && !conflict_valid && level != TOP;
    accept         = conflict_valid && conflict_ready;
    sb_wr_en       = (decide_valid && decide_ready) || (state == FLIP && !sb_full);
    sb_pop         = state == SCAN && !sb_empty;
    sb_din         = state == FLIP;
    unassign_valid = sb_pop;
    unassign_level = level;
    flip_valid     = state == FLIP;
    bt_busy        = state != IDLE;
    unsat          = state == UNSAT;
    inc            = sb_wr_en && level != TOP;
    dec            = sb_pop && level != '0;
    level_next     = inc ? level + LVL_W'(1) : dec ? level - LVL_W'(1) : level;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state      <= IDLE;
      level      <= '0;
      flip_level <= '0;
      err        <= 1'b0;
    end else begin
      level <= level_next;
      // occupancy and stack flags must agree whenever the stack is quiescent
      err   <= err | (state == IDLE && (((level == '0) != sb_empty) || ((level == TOP) != sb_full)));
      if (state == SCAN && !sb_empty && !sb_front) flip_level <= level;
      case (state)
        IDLE:    state <= accept ? SCAN : IDLE;
        SCAN:    state <= sb_empty ? UNSAT : sb_front ? SCAN : FLIP;
        FLIP:    state <= IDLE;
        default: state <= UNSAT;
      endcase
    end
`ifdef BT_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      conflict_cnt <= '0;
      max_level    <= '0;
    end else begin
      conflict_cnt <= conflict_cnt + 32'(accept && !(&conflict_cnt));
      max_level    <= level_next > max_level ? level_next : max_level;
    end
`endif
endmodule

// File: tb/tb_dpll_backtrack_ctrl.sv
// tb_dpll_backtrack_ctrl: scoreboard bench with a Stack_bool model and a queue-based DPLL reference.
module tb_dpll_backtrack_ctrl;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;
  localparam int EV_U = 0, EV_F = 1, EV_X = 2;
  typedef struct {int kind; int lvl; int cyc;} ev_t;
  logic clock = 0, reset = 1, decide_valid = 0, conflict_valid = 0, lie = 0;
  logic decide_ready, conflict_ready, sb_front, sb_full, sb_empty, sb_wr_en, sb_pop, sb_din;
  logic unassign_valid, flip_valid, bt_busy, unsat, err;
  logic [LVL_W-1:0] level, unassign_level, flip_level;
`ifdef BT_STATS_EN
  logic [31:0] conflict_cnt;
  logic [LVL_W-1:0] max_level;
`endif
  int checks = 0, errors = 0, cyc = 0, cnt = 0;
  int m_cnt = 0, m_max = 0;
  bit m_unsat = 0, m_err = 0, unsat_seen = 0;
  bit rs[$];
  ev_t q[$];
  logic mem [DEPTH];
  dpll_backtrack_ctrl #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clock(clock), .reset(reset), .decide_valid(decide_valid), .decide_ready(decide_ready),
    .conflict_valid(conflict_valid), .conflict_ready(conflict_ready), .sb_front(sb_front),
    .sb_full(sb_full), .sb_empty(sb_empty), .sb_wr_en(sb_wr_en), .sb_pop(sb_pop), .sb_din(sb_din),
    .level(level), .unassign_valid(unassign_valid), .unassign_level(unassign_level),
    .flip_valid(flip_valid), .flip_level(flip_level), .bt_busy(bt_busy), .unsat(unsat), .err(err)
`ifdef BT_STATS_EN
    , .conflict_cnt(conflict_cnt), .max_level(max_level)
`endif
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always @(posedge clock or posedge reset)
    if (reset) cnt <= 0;
    else if (sb_wr_en && cnt < DEPTH) begin
      mem[cnt] <= sb_din;
      cnt <= cnt + 1;
    end else if (sb_pop && cnt > 0) cnt <= cnt - 1;
  assign sb_front = cnt > 0 ? mem[cnt-1] : 1'b0;
  assign sb_empty = (cnt == 0) ^ lie;
  assign sb_full  = cnt == DEPTH;

  function automatic void chk(string n, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", n, got, exp, cyc);
    end
  endfunction

  function automatic void expect_ev(int kind, int lvl);
    ev_t e;
    if (q.size() == 0) chk("unexpected_event_kind", kind, -1);
    else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_level", lvl, e.lvl);
      chk("event_cycle", cyc, e.cyc);
    end
  endfunction

  always @(negedge clock)
    if (!reset) begin
      if (sb_wr_en || sb_pop) begin
        chk("wr_pop_exclusive", sb_wr_en && sb_pop, 0);
        chk("push_when_full", sb_wr_en && sb_full, 0);
        chk("pop_when_empty", sb_pop && sb_empty, 0);
      end
      if (unassign_valid) expect_ev(EV_U, int'(unassign_level));
      if (flip_valid) expect_ev(EV_F, int'(flip_level));
      if (unsat && !unsat_seen) begin
        unsat_seen = 1;
        expect_ev(EV_X, 0);
      end
    end

  // DPLL rule: drop tried levels, then flip the newest untried one, or give up when none is left
  function automatic void model_conflict(int acc);
    int cy = acc + 1, lv;
    if (m_cnt != 32'hffff_ffff) m_cnt++;
    while (rs.size() > 0 && rs[$]) begin
      q.push_back('{EV_U, rs.size(), cy});
      void'(rs.pop_back());
      cy++;
    end
    if (rs.size() == 0) begin
      q.push_back('{EV_X, 0, cy + 1});
      m_unsat = 1;
    end else begin
      lv = rs.size();
      q.push_back('{EV_U, lv, cy});
      void'(rs.pop_back());
      q.push_back('{EV_F, lv, cy + 1});
      rs.push_back(1'b1);
    end
  endfunction

  task automatic check_idle();
    chk("level", level, rs.size());
    chk("stack_depth", cnt, rs.size());
    for (int i = 0; i < rs.size() && i < DEPTH; i++) chk("stack_bit", mem[i], rs[i]);
    chk("unsat", unsat, m_unsat);
    chk("bt_busy", bt_busy, m_unsat);
    chk("err", err, m_err);
    chk("pending_events", q.size(), 0);
`ifdef BT_STATS_EN
    chk("conflict_cnt", conflict_cnt, m_cnt);
    chk("max_level", max_level, m_max);
`endif
  endtask

  task automatic reset_all();
    @(posedge clock);
    #1 reset = 1;
    q.delete();
    rs.delete();
    {m_unsat, m_err, unsat_seen} = '0;
    m_cnt = 0;
    m_max = 0;
    @(posedge clock);
    #1 reset = 0;
  endtask

  task automatic do_req(input bit d, input bit c);
    bit edr, ecr, acc_c, acc_d;
    int i = 0;
    @(posedge clock);
    #1 decide_valid = d;
    conflict_valid = c;
    @(negedge clock);
    ecr = !m_unsat;
    edr = !m_unsat && rs.size() < DEPTH && !c;
    chk("conflict_ready", conflict_ready, ecr);
    chk("decide_ready", decide_ready, edr);
    acc_c = c && ecr;
    acc_d = d && edr;
    chk("push_strobe", sb_wr_en, acc_d);
    if (acc_d) begin
      rs.push_back(1'b0);
      if (rs.size() > m_max) m_max = rs.size();
    end
    if (acc_c) model_conflict(cyc);
    @(posedge clock);
    #1 decide_valid = 0;
    conflict_valid = 0;
    if (acc_c) begin
      while (bt_busy && !unsat && i < 40) begin
        @(negedge clock);
        i++;
      end
      chk("unwind_timeout", i < 40, 1);
    end
    @(negedge clock);
    check_idle();
  endtask

  initial begin
    #2;
    chk("rst_level", level, 0);
    chk("rst_conflict_ready", conflict_ready, 0);
    chk("rst_decide_ready", decide_ready, 0);
    chk("rst_strobes", {sb_wr_en, sb_pop, sb_din, unassign_valid, flip_valid}, 0);
    chk("rst_flags", {bt_busy, unsat, err}, 0);
    @(posedge clock);
    #1 reset = 0;
    // basic push/pop
    repeat (3) do_req(1, 0);
    do_req(0, 1);
    // multi-level unwind: build 0,1,1 then conflict
    reset_all();
    do_req(1, 0);
    repeat (2) begin do_req(1, 0); do_req(0, 1); end
    do_req(0, 1);
    // exhaustion: build 1,1 then conflict, then requests ignored
    reset_all();
    do_req(1, 0); do_req(0, 1); do_req(1, 0); do_req(0, 1);
    do_req(0, 1);
    do_req(1, 0); do_req(0, 1); do_req(1, 1);
    // full boundary and simultaneous requests
    reset_all();
    repeat (DEPTH + 1) do_req(1, 0);
    do_req(1, 1);
    // reset during a three-level unwind: build 0,1,1,1 then conflict
    reset_all();
    do_req(1, 0);
    repeat (3) begin do_req(1, 0); do_req(0, 1); end
    @(posedge clock);
    #1 conflict_valid = 1;
    @(negedge clock);
    chk("conflict_ready", conflict_ready, 1);
    model_conflict(cyc);
    @(posedge clock);
    #1 conflict_valid = 0;
    @(posedge clock);
    #2 reset = 1;
    #1;
    chk("midscan_level", level, 0);
    chk("midscan_pulses", {unassign_valid, flip_valid, sb_pop, sb_wr_en, sb_din}, 0);
    chk("midscan_flags", {bt_busy, unsat, err, conflict_ready, decide_ready}, 0);
`ifdef BT_STATS_EN
    chk("midscan_conflict_cnt", conflict_cnt, 0);
`endif
    q.delete();
    rs.delete();
    {m_unsat, m_err, unsat_seen} = '0;
    m_cnt = 0;
    m_max = 0;
    @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    check_idle();
    // stack flags disagreeing with level must raise sticky err
    lie = 1;
    repeat (3) @(negedge clock);
    chk("err_on_mismatch", err, 1);
    lie = 0;
    @(negedge clock);
    chk("err_sticky", err, 1);
    reset_all();
    // randomized traffic
    repeat (200) begin
      int r = $urandom_range(0, 9);
      if (m_unsat) reset_all();
      else if (r < 6) do_req(1, 0);
      else if (r < 9) do_req(0, 1);
      else do_req(1, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
